// File: rtl/fpu_resp_buf_pkg.sv
// Shared FPU definitions: operand/flag widths, flag bit positions, response record.
package fpu_defs;

   localparam int unsigned C_OP = 32;

   // Core flag vector, packed as {Inf,IV,IX,Zero,UF,OF}
   localparam int unsigned C_FLAGS     = 6;
   localparam int unsigned C_FLAG_OF   = 0;
   localparam int unsigned C_FLAG_UF   = 1;
   localparam int unsigned C_FLAG_ZERO = 2;
   localparam int unsigned C_FLAG_IX   = 3;
   localparam int unsigned C_FLAG_IV   = 4;
   localparam int unsigned C_FLAG_INF  = 5;

   // RISC-V fflags, packed as {NV,DZ,OF,UF,NX}
   localparam int unsigned C_FFLAGS    = 5;
   localparam int unsigned C_FFLAG_NX  = 0;
   localparam int unsigned C_FFLAG_UF  = 1;
   localparam int unsigned C_FFLAG_OF  = 2;
   localparam int unsigned C_FFLAG_DZ  = 3;
   localparam int unsigned C_FFLAG_NV  = 4;

   typedef struct packed {
      logic [C_OP-1:0]    result;
      logic [C_FLAGS-1:0] flags;
   } fpu_resp_t;

   // Map core flags onto the fflags layout; the core never reports divide-by-zero.
   function automatic logic [C_FFLAGS-1:0] to_fflags(input logic [C_FLAGS-1:0] f);
      logic [C_FFLAGS-1:0] r;
      r             = '0;
      r[C_FFLAG_NV] = f[C_FLAG_IV];
      r[C_FFLAG_OF] = f[C_FLAG_OF];
      r[C_FFLAG_UF] = f[C_FLAG_UF];
      r[C_FFLAG_NX] = f[C_FLAG_IX];
      return r;
   endfunction

endpackage

// File: rtl/fpu_resp_buf_if.sv
// Result output port of the FPU response buffer (valid/ready with result, flags, tag).
interface fpu_resp_buf_if #(
   parameter int unsigned TAG_WIDTH = 5
) ();
   import fpu_defs::*;

   logic                 Out_Valid_SO;
   logic                 Out_Ready_SI;
   logic [C_OP-1:0]      Out_Result_DO;
   logic [C_FLAGS-1:0]   Out_Flags_DO;
   logic [TAG_WIDTH-1:0] Out_Tag_DO;

   modport master (
      output Out_Valid_SO, Out_Result_DO, Out_Flags_DO, Out_Tag_DO,
      input  Out_Ready_SI
   );

   modport slave (
      input  Out_Valid_SO, Out_Result_DO, Out_Flags_DO, Out_Tag_DO,
      output Out_Ready_SI
   );
endinterface

// File: rtl/fpu_resp_fifo.sv
// Synchronous FIFO with async active-high reset; storage resets to zero so the
// head reads 0 while nothing has been written.
module fpu_resp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fpu_resp_buf.sv
// Credit-gated response buffer behind a fixed-latency FPU core: tracks issued
// tags, buffers results, presents them on valid/ready, keeps sticky fflags.
module fpu_resp_buf
   import fpu_defs::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TAG_WIDTH = 5,
   parameter int unsigned LATENCY   = 1
) (
   input  logic                 Clk_CI,
   input  logic                 Rst_RI,
   input  logic                 Issue_SI,
   input  logic [TAG_WIDTH-1:0] Tag_DI,
   output logic                 Issue_Ready_SO,
   output logic                 Enable_SO,
   input  logic                 Valid_SI,
   input  logic [C_OP-1:0]      Result_DI,
   input  logic [C_FLAGS-1:0]   Flags_DI,
   fpu_resp_buf_if.master       out_if,
   output logic [C_FFLAGS-1:0]  Fflags_DO,
   input  logic                 Fflags_Clr_SI,
   output logic                 Err_SO
);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned EW = $bits(fpu_resp_t) + TAG_WIDTH;

   logic [CW-1:0]        inflight_q, inflight_d;
   logic [LATENCY-1:0]   tag_vld_q, tag_vld_d;
   logic [TAG_WIDTH-1:0] tag_q [LATENCY];
   logic [TAG_WIDTH-1:0] tag_d [LATENCY];
   logic [C_FFLAGS-1:0]  fflags_q, fflags_d;
   logic                 err_q, err_d;

   logic [CW-1:0]        occ;
   logic [CW:0]          credit_sum;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop;
   logic                 last_vld;
   logic [TAG_WIDTH-1:0] last_tag;
   fpu_resp_t            wr_resp, head_resp;
   logic [TAG_WIDTH-1:0] head_tag;
   logic [EW-1:0]        fifo_rdata;

   // Credits count both buffered and in-flight results, so a full pipeline can
   // always drain into the FIFO; only registered state feeds Issue_Ready_SO.
   assign credit_sum     = {1'b0, occ} + {1'b0, inflight_q};
   assign Issue_Ready_SO = (credit_sum < (CW+1)'(DEPTH));
   assign Enable_SO      = Issue_SI & Issue_Ready_SO;

   assign last_vld = tag_vld_q[LATENCY-1];
   assign last_tag = tag_q[LATENCY-1];
   assign push     = Valid_SI;
   assign pop      = ~fifo_empty & out_if.Out_Ready_SI;

   assign wr_resp.result = Result_DI;
   assign wr_resp.flags  = Flags_DI;

   fpu_resp_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (Clk_CI),
      .rst     (Rst_RI),
      .push_i  (push),
      .wdata_i ({wr_resp, last_tag}),
      .pop_i   (out_if.Out_Ready_SI),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (occ)
   );

   assign {head_resp, head_tag} = fifo_rdata;
   assign out_if.Out_Valid_SO   = ~fifo_empty;
   assign out_if.Out_Result_DO  = head_resp.result;
   assign out_if.Out_Flags_DO   = head_resp.flags;
   assign out_if.Out_Tag_DO     = head_tag;
   assign Fflags_DO             = fflags_q;
   assign Err_SO                = err_q;

   // Next-state for in-flight count, tag delay line, sticky fflags and error.
   always_comb begin
      inflight_d = inflight_q + CW'(Enable_SO)
                 - CW'(Valid_SI & (inflight_q != '0));

      tag_vld_d    = tag_vld_q;
      tag_d        = tag_q;
      tag_vld_d[0] = Enable_SO;
      tag_d[0]     = Tag_DI;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_d[i]     = tag_q[i-1];
      end

      // A clear and a push in the same cycle keep the freshly pushed flags.
      fflags_d = (Fflags_Clr_SI ? '0 : fflags_q)
               | (push ? to_fflags(Flags_DI) : '0);

      err_d = err_q
            | (Valid_SI & ~last_vld)
            | (Valid_SI & (inflight_q == '0))
            | (last_vld & ~Valid_SI)
            | (push & fifo_full & ~pop);
   end

   // State registers.
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         inflight_q <= '0;
         tag_vld_q  <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) tag_q[i] <= '0;
         fflags_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         tag_vld_q  <= tag_vld_d;
         tag_q      <= tag_d;
         fflags_q   <= fflags_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_fpu_resp_buf.sv
// Directed bench for fpu_resp_buf with a one-cycle core model in front of it.
module tb_fpu_resp_buf;
   import fpu_defs::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TW    = 5;
   localparam int unsigned LAT   = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                issue = 1'b0;
   logic [TW-1:0]       tag = '0;
   logic                ir, en, vld;
   logic [C_OP-1:0]     res;
   logic [C_FLAGS-1:0]  flg;
   logic                rdy = 1'b0;
   logic                clr = 1'b0;
   logic [C_FFLAGS-1:0] ff;
   logic                err;

   logic [C_OP-1:0]     in_res = '0;
   logic [C_FLAGS-1:0]  in_flg = '0;
   logic                inj_v = 1'b0;
   logic                core_v;
   logic [C_OP-1:0]     core_res;
   logic [C_FLAGS-1:0]  core_flg;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   fpu_resp_buf_if #(.TAG_WIDTH(TW)) oif ();
   assign oif.Out_Ready_SI = rdy;

   fpu_resp_buf #(
      .DEPTH     (DEPTH),
      .TAG_WIDTH (TW),
      .LATENCY   (LAT)
   ) dut (
      .Clk_CI         (clk),
      .Rst_RI         (rst),
      .Issue_SI       (issue),
      .Tag_DI         (tag),
      .Issue_Ready_SO (ir),
      .Enable_SO      (en),
      .Valid_SI       (vld),
      .Result_DI      (res),
      .Flags_DI       (flg),
      .out_if         (oif),
      .Fflags_DO      (ff),
      .Fflags_Clr_SI  (clr),
      .Err_SO         (err)
   );

   always #5 clk = ~clk;

   // Core model: result and flags of an enabled op appear one cycle later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_v   <= 1'b0;
         core_res <= '0;
         core_flg <= '0;
      end else begin
         core_v   <= en;
         core_res <= in_res;
         core_flg <= in_flg;
      end
   end
   assign vld = core_v | inj_v;
   assign res = core_res;
   assign flg = core_flg;

   typedef struct {
      logic                is;
      logic [TW-1:0]       tg;
      logic [C_OP-1:0]     rs;
      logic [C_FLAGS-1:0]  fl;
      logic                rd;
      logic                e_ir;
      logic                e_ov;
      logic [TW-1:0]       e_tg;
      logic [C_OP-1:0]     e_rs;
      logic [C_FLAGS-1:0]  e_fl;
      logic [C_FFLAGS-1:0] e_ff;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic is, input logic [TW-1:0] tg,
                               input logic [C_OP-1:0] rs, input logic [C_FLAGS-1:0] fl,
                               input logic rd, input logic e_ir, input logic e_ov,
                               input logic [TW-1:0] e_tg, input logic [C_OP-1:0] e_rs,
                               input logic [C_FLAGS-1:0] e_fl, input logic [C_FFLAGS-1:0] e_ff);
      vec_t v;
      v.is = is; v.tg = tg; v.rs = rs; v.fl = fl; v.rd = rd;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_tg = e_tg; v.e_rs = e_rs;
      v.e_fl = e_fl; v.e_ff = e_ff;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic is, input logic [TW-1:0] tg, input logic [C_OP-1:0] rs,
                        input logic [C_FLAGS-1:0] fl, input logic rd, input logic cl);
      issue  = is;
      tag    = tg;
      in_res = rs;
      in_flg = fl;
      rdy    = rd;
      clr    = cl;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Rows: single op (tag 3, IX), then back-pressure with DEPTH=4 and a one-cycle pop.
      tbl[0]  = mk(1, 5'd3, 32'h3F800000, 6'b001000, 1, 1, 0, 0, 0, 0, 5'b00000);
      tbl[1]  = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 0, 0, 0, 0, 5'b00000);
      tbl[2]  = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 1, 5'd3, 32'h3F800000, 6'b001000, 5'b00001);
      tbl[3]  = mk(0, 5'd0, 32'h0,        6'b000000, 0, 1, 0, 0, 0, 0, 5'b00001);
      tbl[4]  = mk(1, 5'd0, 32'h100,      6'b000000, 0, 1, 0, 0, 0, 0, 5'b00001);
      tbl[5]  = mk(1, 5'd1, 32'h101,      6'b000000, 0, 1, 0, 0, 0, 0, 5'b00001);
      tbl[6]  = mk(1, 5'd2, 32'h102,      6'b000000, 0, 1, 1, 5'd0, 32'h100, 0, 5'b00001);
      tbl[7]  = mk(1, 5'd3, 32'h103,      6'b000000, 0, 1, 1, 5'd0, 32'h100, 0, 5'b00001);
      tbl[8]  = mk(1, 5'd4, 32'h104,      6'b000000, 0, 0, 1, 5'd0, 32'h100, 0, 5'b00001);
      tbl[9]  = mk(1, 5'd4, 32'h104,      6'b000000, 0, 0, 1, 5'd0, 32'h100, 0, 5'b00001);
      tbl[10] = mk(1, 5'd4, 32'h104,      6'b000000, 1, 0, 1, 5'd0, 32'h100, 0, 5'b00001);
      tbl[11] = mk(1, 5'd4, 32'h104,      6'b000000, 0, 1, 1, 5'd1, 32'h101, 0, 5'b00001);
      tbl[12] = mk(0, 5'd0, 32'h0,        6'b000000, 1, 0, 1, 5'd1, 32'h101, 0, 5'b00001);
      tbl[13] = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 1, 5'd2, 32'h102, 0, 5'b00001);
      tbl[14] = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 1, 5'd3, 32'h103, 0, 5'b00001);
      tbl[15] = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 1, 5'd4, 32'h104, 0, 5'b00001);
      tbl[16] = mk(0, 5'd0, 32'h0,        6'b000000, 1, 1, 0, 0, 0, 0, 5'b00001);

      // Reset state
      #1 rst = 1'b1;
      issue = 1'b1;
      #2;
      chk("rst_ov",  64'(oif.Out_Valid_SO), 64'd0);
      chk("rst_ir",  64'(ir), 64'd1);
      chk("rst_en",  64'(en), 64'd1);
      chk("rst_ff",  64'(ff), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_tag", 64'(oif.Out_Tag_DO), 64'd0);
      chk("rst_res", 64'(oif.Out_Result_DO), 64'd0);
      issue = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Table-driven single op and back-pressure
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].is, tbl[i].tg, tbl[i].rs, tbl[i].fl, tbl[i].rd, 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d_ir", i),  64'(ir), 64'(tbl[i].e_ir));
         chk($sformatf("v%0d_en", i),  64'(en), 64'(tbl[i].is & tbl[i].e_ir));
         chk($sformatf("v%0d_ov", i),  64'(oif.Out_Valid_SO), 64'(tbl[i].e_ov));
         chk($sformatf("v%0d_ff", i),  64'(ff), 64'(tbl[i].e_ff));
         chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
         if (tbl[i].e_ov) begin
            chk($sformatf("v%0d_tag", i), 64'(oif.Out_Tag_DO), 64'(tbl[i].e_tg));
            chk($sformatf("v%0d_res", i), 64'(oif.Out_Result_DO), 64'(tbl[i].e_rs));
            chk($sformatf("v%0d_flg", i), 64'(oif.Out_Flags_DO), 64'(tbl[i].e_fl));
         end
         tick();
      end

      // Streaming 20 ops through the wrapping FIFO with no bubbles
      for (int c = 0; c < 24; c++) begin
         drive(c < 20, TW'(c), 32'h200 + c, '0, 1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("s%0d_ir", c), 64'(ir), 64'd1);
         chk($sformatf("s%0d_ov", c), 64'(oif.Out_Valid_SO), 64'(c >= 2 && c <= 21));
         if (c >= 2 && c <= 21) begin
            chk($sformatf("s%0d_tag", c), 64'(oif.Out_Tag_DO), 64'(c - 2));
            chk($sformatf("s%0d_res", c), 64'(oif.Out_Result_DO), 64'(32'h200 + c - 2));
         end
         tick();
      end
      chk("stream_err", 64'(err), 64'd0);

      // Flag clear racing a push: NV first, then clear together with an OF push
      drive(1, 5'd7, 32'h300, 6'b010000, 1, 1);  // clears the earlier NX
      tick();
      drive(0, 5'd0, 32'h0, 6'b000000, 1, 0);    // IV result pushes
      tick();
      @(negedge clk);
      chk("clr_nv", 64'(ff), 64'b10000);
      drive(1, 5'd8, 32'h301, 6'b000001, 1, 0);
      tick();
      drive(0, 5'd0, 32'h0, 6'b000000, 1, 1);    // OF push with clear
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_race", 64'(ff), 64'b00100);
      tick();
      chk("clr_hold", 64'(ff), 64'b00100);
      chk("clr_err",  64'(err), 64'd0);

      // Protocol error: result with nothing issued
      inj_v = 1'b1;
      tick();
      inj_v = 1'b0;
      @(negedge clk);
      chk("perr_set", 64'(err), 64'd1);
      tick(); tick(); tick();
      chk("perr_hold", 64'(err), 64'd1);

      // Reset with 3 entries buffered and 1 in flight
      for (int c = 0; c < 4; c++) begin
         drive(1, TW'(10 + c), 32'h400 + c, 6'b001000, 0, 0);
         @(negedge clk);
         chk($sformatf("fill%0d_ir", c), 64'(ir), 64'd1);
         tick();
      end
      drive(1, 5'd0, 32'h0, 6'b000000, 0, 0);
      chk("pre_ov",  64'(oif.Out_Valid_SO), 64'd1);
      chk("pre_ir",  64'(ir), 64'd0);
      chk("pre_tag", 64'(oif.Out_Tag_DO), 64'd10);
      #2 rst = 1'b1;
      #1;
      chk("mid_ov",  64'(oif.Out_Valid_SO), 64'd0);
      chk("mid_ir",  64'(ir), 64'd1);
      chk("mid_en",  64'(en), 64'd1);
      chk("mid_ff",  64'(ff), 64'd0);
      chk("mid_err", 64'(err), 64'd0);
      issue = 1'b0;
      tick();
      rst = 1'b0;

      // Recovery: one op after reset
      drive(1, 5'd9, 32'h3F800000, 6'b000000, 1, 0);
      tick();
      drive(0, 5'd0, 32'h0, 6'b000000, 1, 0);
      tick();
      @(negedge clk);
      chk("rec_ov",  64'(oif.Out_Valid_SO), 64'd1);
      chk("rec_tag", 64'(oif.Out_Tag_DO), 64'd9);
      chk("rec_err", 64'(err), 64'd0);
      tick();
      @(negedge clk);
      chk("rec_empty", 64'(oif.Out_Valid_SO), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
